score_ctrl: RTL and testbench

- Pong match sequencer and scoreboard.
- Consumes one-cycle point pulses from the ball/collision logic, keeps per-player BCD scores, and runs the serve/play/game-over state machine.
- Produces the six 4-bit digit codes consumed by the seven-segment display decoder.
- Codes 0-9 are digits; code 15 is blank.

---
 rtl/score_ctrl.sv | 147 ++++++++++++++
 tb/tb_score_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// Pong match sequencer and scoreboard: serve/play/over FSM, per-player BCD scores,
// and six registered digit codes for the seven-segment decoder (15 = blank).
module score_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] seg0,
  output logic [3:0] seg1,
  output logic [3:0] seg2,
  output logic [3:0] seg3,
  output logic [3:0] seg4,
  output logic [3:0] seg5,
  output logic       play_active,
  output logic       serve_go,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [7:0]    WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [3:0]    BLANK      = 4'hF;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t          state, nxt;
  logic [SW-1:0]   serve_cnt, serve_cnt_d;
  logic [BW-1:0]   blink_cnt, blink_cnt_d;
  logic            blink_off, blink_off_d;
  logic [7:0]      p1_score, p2_score, p1_d, p2_d, p1_inc, p2_inc;
  logic [1:0]      winner_d;
  logic            play_d, go_d, over_d;
  logic [3:0]      seg3_d;
  logic            hit1, hit2;

  // BCD +1 with carry from ones into tens; holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // Simultaneous pulses cancel each other.
  assign hit1   = point_p1 & ~point_p2;
  assign hit2   = point_p2 & ~point_p1;
  assign p1_inc = bcd_inc(p1_score);
  assign p2_inc = bcd_inc(p2_score);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = SERVE;
      SERVE: if (!start && serve_cnt == SERVE_LAST) nxt = PLAY;
      PLAY: begin
        if (hit1)
          nxt = (p1_inc == WIN_BCD) ? OVER : SERVE;
        else if (hit2)
          nxt = (p2_inc == WIN_BCD) ? OVER : SERVE;
      end
      OVER:  if (start) nxt = SERVE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    p1_d     = p1_score;
    p2_d     = p2_score;
    winner_d = winner;
    if (state == PLAY && hit1)
      p1_d = p1_inc;
    if (state == PLAY && hit2)
      p2_d = p2_inc;
    if (state == PLAY && nxt == OVER)
      winner_d = hit1 ? 2'd1 : 2'd2;
    if (state == OVER && start) begin
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      winner_d = 2'd0;
    end

    // Any (re)entry into SERVE, including a restart by start, begins a fresh hold.
    serve_cnt_d = (state == SERVE && nxt == SERVE && !start) ? serve_cnt + SW'(1) : '0;

    if (state == OVER && nxt == OVER) begin
      blink_cnt_d = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
      blink_off_d = blink_off ^ (blink_cnt == BLINK_LAST);
    end else begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end

    play_d = (nxt == PLAY);
    go_d   = (state == SERVE) && (nxt == PLAY);
    over_d = (nxt == OVER);
    seg3_d = (over_d && !blink_off_d) ? {2'b00, winner_d} : BLANK;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      serve_cnt   <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      p1_score    <= 8'h00;
      p2_score    <= 8'h00;
      winner      <= 2'd0;
      play_active <= 1'b0;
      serve_go    <= 1'b0;
      game_over   <= 1'b0;
      seg3        <= BLANK;
    end else begin
      serve_cnt   <= serve_cnt_d;
      blink_cnt   <= blink_cnt_d;
      blink_off   <= blink_off_d;
      p1_score    <= p1_d;
      p2_score    <= p2_d;
      winner      <= winner_d;
      play_active <= play_d;
      serve_go    <= go_d;
      game_over   <= over_d;
      seg3        <= seg3_d;
    end
  end

  assign seg0 = p1_score[3:0];
  assign seg1 = p1_score[7:4];
  assign seg2 = BLANK;
  assign seg4 = p2_score[3:0];
  assign seg5 = p2_score[7:4];

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: a per-cycle vector table for the main match flow,
// plus hand-written sequences for mid-serve reset and a two-digit P2 run.
`timescale 1ns/1ps
module tb_score_ctrl;

  localparam logic [3:0] B = 4'hF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, p1_a = 1'b0, p2_a = 1'b0;
  logic [3:0] s0_a, s1_a, s2_a, s3_a, s4_a, s5_a;
  logic       pa_a, sg_a, go_a;
  logic [1:0] w_a;

  logic       start_b = 1'b0, p1_b = 1'b0, p2_b = 1'b0;
  logic [3:0] s0_b, s1_b, s2_b, s3_b, s4_b, s5_b;
  logic       pa_b, sg_b, go_b;
  logic [1:0] w_b;

  score_ctrl #(.WIN_SCORE(3), .SERVE_CYCLES(4), .BLINK_CYCLES(2)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .point_p1(p1_a), .point_p2(p2_a),
    .seg0(s0_a), .seg1(s1_a), .seg2(s2_a), .seg3(s3_a), .seg4(s4_a), .seg5(s5_a),
    .play_active(pa_a), .serve_go(sg_a), .game_over(go_a), .winner(w_a));

  score_ctrl #(.WIN_SCORE(12), .SERVE_CYCLES(4), .BLINK_CYCLES(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .point_p1(p1_b), .point_p2(p2_b),
    .seg0(s0_b), .seg1(s1_b), .seg2(s2_b), .seg3(s3_b), .seg4(s4_b), .seg5(s5_b),
    .play_active(pa_b), .serve_go(sg_b), .game_over(go_b), .winner(w_b));

  typedef struct {
    logic       st, p1, p2;
    logic [3:0] s0, s1, s3, s4;
    logic       pa, sg, go;
    logic [1:0] w;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, p1, p2, input logic [3:0] s0, s1, s3, s4,
                              input logic pa, sg, go, input logic [1:0] w);
    vec_t v;
    v.st = st; v.p1 = p1; v.p2 = p2;
    v.s0 = s0; v.s1 = s1; v.s3 = s3; v.s4 = s4;
    v.pa = pa; v.sg = sg; v.go = go; v.w = w;
    return v;
  endfunction

  function automatic logic [31:0] pack_a();
    return {3'b000, s0_a, s1_a, s2_a, s3_a, s4_a, s5_a, pa_a, sg_a, go_a, w_a};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {3'b000, v.s0, v.s1, B, v.s3, v.s4, 4'h0, v.pa, v.sg, v.go, v.w};
  endfunction

  task automatic wait_play_b();
    int n = 0;
    while (pa_b !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b play wait", {31'd0, pa_b}, 32'd1);
  endtask

  initial begin
    // Each row: inputs before an edge, outputs expected right after it.
    vq.push_back(mk(0,1,0, 0,0,B,0, 0,0,0,0)); // r0 idle, point ignored
    vq.push_back(mk(0,0,0, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(1,0,0, 0,0,B,0, 0,0,0,0)); // r2 start
    vq.push_back(mk(0,1,0, 0,0,B,0, 0,0,0,0)); // serve, points ignored
    vq.push_back(mk(0,0,1, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,B,0, 1,1,0,0)); // r6 play, serve_go
    vq.push_back(mk(0,0,0, 0,0,B,0, 1,0,0,0));
    vq.push_back(mk(0,1,1, 0,0,B,0, 1,0,0,0)); // both pulses discarded
    vq.push_back(mk(0,1,0, 1,0,B,0, 0,0,0,0)); // r9 P1 scores
    vq.push_back(mk(0,0,0, 1,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,0, 1,1,0,0)); // r13
    vq.push_back(mk(1,0,0, 1,0,B,0, 1,0,0,0)); // start in play ignored
    vq.push_back(mk(1,0,1, 1,0,B,1, 0,0,0,0)); // play takes the point over start
    vq.push_back(mk(1,0,0, 1,0,B,1, 0,0,0,0)); // r16 start restarts hold
    vq.push_back(mk(0,0,0, 1,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 1,0,B,1, 1,1,0,0)); // r20
    vq.push_back(mk(0,1,0, 2,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 2,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 2,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 2,0,B,1, 0,0,0,0));
    vq.push_back(mk(0,0,0, 2,0,B,1, 1,1,0,0)); // r25
    vq.push_back(mk(0,1,0, 3,0,1,1, 0,0,1,1)); // r26 win -> over, visible
    vq.push_back(mk(0,0,0, 3,0,1,1, 0,0,1,1));
    vq.push_back(mk(0,0,0, 3,0,B,1, 0,0,1,1));
    vq.push_back(mk(0,0,0, 3,0,B,1, 0,0,1,1));
    vq.push_back(mk(0,0,0, 3,0,1,1, 0,0,1,1));
    vq.push_back(mk(0,1,0, 3,0,1,1, 0,0,1,1)); // point in over ignored
    vq.push_back(mk(0,0,0, 3,0,B,1, 0,0,1,1));
    vq.push_back(mk(1,0,1, 0,0,B,0, 0,0,0,0)); // r33 restart from over
    vq.push_back(mk(0,0,0, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,B,0, 0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,B,0, 1,1,0,0)); // r37

    repeat (3) @(posedge clk);
    #1;
    chk("reset values", pack_a(), pack_exp(mk(0,0,0, 0,0,B,0, 0,0,0,0)));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      start_a = vq[i].st;
      p1_a    = vq[i].p1;
      p2_a    = vq[i].p2;
      @(posedge clk); #1;
      chk($sformatf("vec %0d", i), pack_a(), pack_exp(vq[i]));
    end
    start_a = 1'b0; p1_a = 1'b0; p2_a = 1'b0;

    // Reset asserted mid-serve takes effect without a clock edge.
    p1_a = 1'b1;
    @(posedge clk); #1;
    p1_a = 1'b0;
    chk("pre-reset score", pack_a(), pack_exp(mk(0,0,0, 1,0,B,0, 0,0,0,0)));
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("async reset", pack_a(), pack_exp(mk(0,0,0, 0,0,B,0, 0,0,0,0)));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle after reset", {30'd0, pa_a, sg_a}, 32'd0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold after reset", {30'd0, pa_a, sg_a}, 32'd0);
    @(posedge clk); #1;
    chk("serve_go after reset", {30'd0, pa_a, sg_a}, 32'd3);

    // Two-digit P2 run to WIN_SCORE=12.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wait_play_b();
      p2_b = 1'b1;
      @(posedge clk); #1;
      p2_b = 1'b0;
      chk($sformatf("b p2 digits k=%0d", k), {24'd0, s5_b, s4_b}, {24'd0, 4'(k / 10), 4'(k % 10)});
      chk($sformatf("b status k=%0d", k), {27'd0, go_b, w_b, pa_b, s0_b == 4'd0 && s1_b == 4'd0},
          {27'd0, (k == 12), (k == 12) ? 2'd2 : 2'd0, 1'b0, 1'b1});
    end
    chk("b winner seg3", {28'd0, s3_b}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
